// File: rtl/mdio_pkg.sv
// Shared types and Clause 22 frame layout for the MDIO management master.
package mdio_pkg;

    typedef enum logic [2:0] {
        RST_HOLD,
        RST_WAIT,
        IDLE,
        FRAME,
        DONE
    } state_t;

    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] ST       = 2'b01;

    localparam int FRAME_BITS = 64;
    localparam int ST_BIT     = 32;
    localparam int OP_BIT     = 34;
    localparam int PHYAD_BIT  = 36;
    localparam int REGAD_BIT  = 41;
    localparam int TA_BIT     = 46;
    localparam int DATA_BIT   = 48;

    // Reads carry ones in TA/data so the line idles high if ever driven there.
    function automatic logic [FRAME_BITS-1:0] build_frame(
        input logic        write,
        input logic [4:0]  phyad,
        input logic [4:0]  regad,
        input logic [15:0] wdata
    );
        return {32'hFFFF_FFFF, ST, (write ? OP_WRITE : OP_READ), phyad, regad,
                (write ? 2'b10 : 2'b11), (write ? wdata : 16'hFFFF)};
    endfunction

endpackage

// File: rtl/mdio_clk_gen.sv
// MDC generator: free-runs only while enabled, parks low otherwise, and
// flags the cycles on which MDC is about to rise or fall.
module mdio_clk_gen #(
    parameter int CLK_DIV = 40
) (
    input  logic clk_200,
    input  logic sys_rstn,
    input  logic en,
    output logic mdc,
    output logic fall_stb,
    output logic rise_stb
);

    localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;
    logic             half_done;

    assign half_done = en && (div_cnt == DIV_LAST);
    assign rise_stb  = half_done && !mdc;
    assign fall_stb  = half_done && mdc;

    always_ff @(posedge clk_200) begin
        if (!sys_rstn || !en) begin
            div_cnt <= '0;
            mdc     <= 1'b0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            mdc     <= ~mdc;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mdio_phy_master.sv
// Clause 22 MDIO master with PHY reset sequencing; a lost clock lock or
// system reset aborts any frame and restarts the PHY reset sequence.
module mdio_phy_master
    import mdio_pkg::*;
#(
    parameter int CLK_DIV         = 40,
    parameter int PHY_RST_CYCLES  = 2_000_000,
    parameter int PHY_WAIT_CYCLES = 1_000_000
) (
    input  logic        clk_200,
    input  logic        sys_rstn,
    input  logic        i_lock,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [4:0]  cmd_phyad,
    input  logic [4:0]  cmd_regad,
    input  logic [15:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    output logic        phy_resetn,
    output logic        phy_ready,
    output logic        mdc,
    output logic        mdio_o,
    output logic        mdio_t,
    input  logic        mdio_i
);

    localparam logic [31:0] RST_LAST  = 32'(PHY_RST_CYCLES - 1);
    localparam logic [31:0] WAIT_LAST = 32'(PHY_WAIT_CYCLES - 1);
    localparam logic [5:0]  LAST_BIT  = 6'(FRAME_BITS - 1);
    localparam logic [5:0]  TA_SAMPLE = 6'(TA_BIT + 1);
    localparam logic [5:0]  TRI_FROM  = 6'(TA_BIT - 1);

    state_t                  state;
    state_t                  next_state;
    logic                    abort;
    logic                    mdc_en;
    logic                    fall_stb;
    logic                    rise_stb;
    logic [31:0]             seq_cnt;
    logic [5:0]              bit_cnt;
    logic [FRAME_BITS-1:0]   frame_word;
    logic [FRAME_BITS-1:0]   shreg;
    logic [15:0]             rd_shift;
    logic                    ta_bit;
    logic                    is_read;

    assign abort      = !sys_rstn || !i_lock;
    assign mdc_en     = (state == FRAME) && !abort;
    assign frame_word = build_frame(cmd_write, cmd_phyad, cmd_regad, cmd_wdata);

    assign cmd_ready  = (state == IDLE);
    assign phy_ready  = (state == IDLE) || (state == FRAME) || (state == DONE);
    assign phy_resetn = (state != RST_HOLD);
    assign rsp_valid  = (state == DONE);

    mdio_clk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_gen (
        .clk_200  (clk_200),
        .sys_rstn (sys_rstn),
        .en       (mdc_en),
        .mdc      (mdc),
        .fall_stb (fall_stb),
        .rise_stb (rise_stb)
    );

    always_ff @(posedge clk_200) begin
        if (!sys_rstn) begin
            state <= RST_HOLD;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (!i_lock) begin
            next_state = RST_HOLD;
        end else begin
            case (state)
                RST_HOLD: if (seq_cnt == RST_LAST)  next_state = RST_WAIT;
                RST_WAIT: if (seq_cnt == WAIT_LAST) next_state = IDLE;
                IDLE:     if (cmd_valid)            next_state = FRAME;
                FRAME:    if (fall_stb && (bit_cnt == LAST_BIT)) next_state = DONE;
                DONE:     next_state = IDLE;
                default:  next_state = RST_HOLD;
            endcase
        end
    end

    always_ff @(posedge clk_200) begin
        if (abort) begin
            seq_cnt   <= '0;
            bit_cnt   <= '0;
            shreg     <= '1;
            rd_shift  <= '0;
            ta_bit    <= 1'b0;
            is_read   <= 1'b0;
            mdio_o    <= 1'b1;
            mdio_t    <= 1'b1;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                RST_HOLD: seq_cnt <= (seq_cnt == RST_LAST)  ? '0 : seq_cnt + 32'd1;
                RST_WAIT: seq_cnt <= (seq_cnt == WAIT_LAST) ? '0 : seq_cnt + 32'd1;
                IDLE: begin
                    // Bit 0 is presented on the accept edge so it is on the
                    // pad for the whole first MDC low phase.
                    if (cmd_valid) begin
                        mdio_o  <= frame_word[FRAME_BITS-1];
                        mdio_t  <= 1'b0;
                        shreg   <= {frame_word[FRAME_BITS-2:0], 1'b1};
                        bit_cnt <= '0;
                        is_read <= !cmd_write;
                    end
                end
                FRAME: begin
                    if (rise_stb) begin
                        if (bit_cnt == TA_SAMPLE) ta_bit <= mdio_i;
                        rd_shift <= {rd_shift[14:0], mdio_i};
                    end
                    if (fall_stb) begin
                        if (bit_cnt == LAST_BIT) begin
                            mdio_o    <= 1'b1;
                            mdio_t    <= 1'b1;
                            rsp_rdata <= is_read ? rd_shift : 16'h0000;
                            rsp_err   <= is_read && ta_bit;
                        end else begin
                            mdio_o  <= shreg[FRAME_BITS-1];
                            shreg   <= {shreg[FRAME_BITS-2:0], 1'b1};
                            mdio_t  <= is_read && (bit_cnt >= TRI_FROM);
                            bit_cnt <= bit_cnt + 6'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
